// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button debouncer.
// Width helper and inactive-pin-level derivation.
package btn_pkg;

  localparam int BTN_DEBOUNCE_DEF = 128;
  localparam int BTN_LONG_DEF     = 1000;

  function automatic int btn_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic btn_inactive(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: 2-flop sync, symmetric debounce,
// press/release pulses and a once-per-hold long pulse.
module button_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_DEF,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = btn_clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic INACT = btn_inactive(ACTIVE_LOW);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic [DW-1:0] r_dcnt;

  logic w_act;
  logic w_diff;
  logic w_flip;

  assign w_act  = r_s2 ^ INACT;
  assign w_diff = (w_act != r_level);
  assign w_flip = w_diff && (r_dcnt == DLAST);

  // Pin synchroniser, reset to the idle pin level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= INACT;
      r_s2 <= INACT;
    end else begin
      r_s1 <= i_button;
      r_s2 <= r_s1;
    end
  end

  // Debounce: any agreeing sample restarts the run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_flip & ~r_level;
      r_release <= w_flip & r_level;
      if (!w_diff || w_flip) begin
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

  if (LONG_CYCLES > 0) begin : g_hold
    localparam int HW = btn_clog2(LONG_CYCLES) + 1;
    localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HPRE = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] r_hcnt;
    logic          r_long;

    // Hold timer; a release on the threshold edge wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= r_level & ~w_flip & (r_hcnt == HPRE);
        if (!r_level || w_flip) begin
          r_hcnt <= '0;
        end else if (r_hcnt != HMAX) begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end

    assign o_long = r_long;
  end else begin : g_nohold
    assign o_long = 1'b0;
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer.
// One independent button_chan per pin.
module button_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_DEF,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_release;
  logic [N_CH-1:0] w_long;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_button  (button_in[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_long    (w_long[g])
    );
  end

  assign level_o   = w_level;
  assign press_o   = w_press;
  assign release_o = w_release;
  assign long_o    = w_long;

endmodule
